// File: rtl/gray_decode_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gray_arb_pkg
//  Description : Default sizes and helpers for the shared Gray-to-binary arbiter
//  Revision    : 1.0  initial release
// ============================================================================
package gray_arb_pkg;

    localparam int unsigned c_default_w    = 3;
    localparam int unsigned c_default_n    = 4;
    localparam int unsigned c_default_cntw = 16;

    // Smallest r >= 1 with 2**r >= n, so a two-requester build still has a 1-bit ID.
    function automatic int unsigned clog2_n(input int unsigned n);
        for (int unsigned r = 1; r < 32; r++) begin
            if ((32'd1 << r) >= n) return r;
        end
        return 32;
    endfunction

    function automatic logic [c_default_w-1:0] gray2bin(input logic [c_default_w-1:0] g);
        logic [c_default_w-1:0] b;
        b[c_default_w-1] = g[c_default_w-1];
        for (int i = int'(c_default_w) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_decode_arbiter_g2b.sv
`default_nettype none
// ============================================================================
//  Module      : gray_to_bin_w
//  Description : Combinational W-bit Gray-to-binary converter
//  Revision    : 1.0  initial release
// ============================================================================
module gray_to_bin_w #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Bit i is the XOR of all Gray bits at or above i; written as independent
    // reductions so no bit of o_bin feeds another.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < int'(W); i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gray_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decode_arbiter
//  Description : Round-robin shares one Gray-to-binary converter among N sources
//  Revision    : 1.0  initial release
// ============================================================================
module gray_decode_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned W    = c_default_w,
    parameter int unsigned N    = c_default_n,
    parameter int unsigned IDW  = clog2_n(N),
    parameter int unsigned CNTW = c_default_cntw
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_gray,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_bin,
    output logic [IDW-1:0]  out_id,
    output logic [CNTW-1:0] conv_count
);

    localparam logic [0:0]      c_s_empty = 1'b0;
    localparam logic [0:0]      c_s_full  = 1'b1;
    localparam logic [IDW-1:0]  c_last    = IDW'(N - 1);
    localparam logic [CNTW-1:0] c_cnt_max = '1;

    logic [0:0]      r_state_q,      w_state_d;
    logic [IDW-1:0]  r_rr_ptr_q,     w_rr_ptr_d;
    logic [W-1:0]    r_out_bin_q,    w_out_bin_d;
    logic [IDW-1:0]  r_out_id_q,     w_out_id_d;
    logic [CNTW-1:0] r_conv_count_q, w_conv_count_d;

    logic [N-1:0]    w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_grant_idx;
    logic            w_can_load;
    logic            w_grant;
    logic [W-1:0]    w_sel_gray;
    logic [W-1:0]    w_sel_bin;

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then unrotate.
    always_comb begin
        w_rot = N'({req_valid, req_valid} >> r_rr_ptr_q);
        w_off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDW'(i);
        end
        w_sum = {1'b0, w_off} + {1'b0, r_rr_ptr_q};
        if (32'(w_sum) >= N) w_grant_idx = IDW'(32'(w_sum) - N);
        else                 w_grant_idx = w_sum[IDW-1:0];

        w_sel_gray = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_grant_idx == IDW'(i)) w_sel_gray = req_gray[i*W +: W];
        end
    end

    gray_to_bin_w #(.W(W)) u_g2b (
        .i_gray (w_sel_gray),
        .o_bin  (w_sel_bin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= c_s_empty;
            r_rr_ptr_q     <= '0;
            r_out_bin_q    <= '0;
            r_out_id_q     <= '0;
            r_conv_count_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_rr_ptr_q     <= w_rr_ptr_d;
            r_out_bin_q    <= w_out_bin_d;
            r_out_id_q     <= w_out_id_d;
            r_conv_count_q <= w_conv_count_d;
        end
    end

    // Grants are suppressed while reset is asserted so no requester sees a false accept.
    always_comb begin
        w_can_load     = (r_state_q == c_s_empty) || out_ready;
        w_grant        = rst_n && w_can_load && (|req_valid);
        w_state_d      = r_state_q;
        w_rr_ptr_d     = r_rr_ptr_q;
        w_out_bin_d    = r_out_bin_q;
        w_out_id_d     = r_out_id_q;
        w_conv_count_d = r_conv_count_q;
        if (w_grant) begin
            w_state_d   = c_s_full;
            w_out_bin_d = w_sel_bin;
            w_out_id_d  = w_grant_idx;
            w_rr_ptr_d  = (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
            if (r_conv_count_q != c_cnt_max) w_conv_count_d = r_conv_count_q + 1'b1;
        end else if (out_ready) begin
            w_state_d = c_s_empty;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_grant_idx] = 1'b1;
        out_valid  = (r_state_q == c_s_full);
        out_bin    = r_out_bin_q;
        out_id     = r_out_id_q;
        conv_count = r_conv_count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_decode_arbiter
//  Description : Vector table plus scoreboard bench for gray_decode_arbiter
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_decode_arbiter;
    import gray_arb_pkg::*;

    localparam int W    = 3;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;
    localparam logic [N*W-1:0] c_g2 = {3'b011, 3'b010, 3'b101, 3'b100};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_gray;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_bin;
    logic [IDW-1:0]  out_id;
    logic [CNTW-1:0] conv_count;

    always #5 clk = ~clk;

    gray_decode_arbiter #(.W(W), .N(N), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_id     (out_id),
        .conv_count (conv_count)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   bin;
    } res_t;

    typedef struct {
        bit             pre_rst;
        logic [N-1:0]   v;
        logic [N*W-1:0] g;
        logic           rdy;
        logic [N-1:0]   exp_rdy;
        logic           exp_vld;
        logic [IDW-1:0] exp_id;
        logic [W-1:0]   exp_bin;
    } vec_t;

    res_t            sb_q[$];
    vec_t            tbl[$];
    logic            m_valid;
    int              m_ptr;
    logic [CNTW-1:0] m_count;
    int              n_pass  = 0;
    int              n_total = 0;
    logic [W-1:0]    bin_tbl [0:7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input bit pr, input logic [N-1:0] v, input logic [N*W-1:0] g,
                                input logic rdy, input logic [N-1:0] er, input logic ev,
                                input logic [IDW-1:0] eid, input logic [W-1:0] eb);
        vec_t e;
        e.pre_rst = pr; e.v = v; e.g = g; e.rdy = rdy;
        e.exp_rdy = er; e.exp_vld = ev; e.exp_id = eid; e.exp_bin = eb;
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_count = '0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // One clock: predict the grant, check combinational and held outputs, update the model.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] g, input logic rdy);
        int           gi;
        logic [N-1:0] er;
        res_t         r;
        req_valid = v; req_gray = g; out_ready = rdy;
        #1;
        gi = (!m_valid || rdy) ? pick(v, m_ptr) : -1;
        er = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        chk("req_ready", req_ready, er);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                chk("out_id", out_id, sb_q[0].id);
                chk("out_bin", out_bin, sb_q[0].bin);
                if (rdy) void'(sb_q.pop_front());
            end
        end
        if (gi >= 0) begin
            r.id  = IDW'(gi);
            r.bin = gray2bin(g[gi*W +: W]);
            sb_q.push_back(r);
            m_ptr   = (gi + 1) % N;
            m_valid = 1'b1;
            if (m_count != '1) m_count++;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("conv_count", conv_count, m_count);
    endtask

    task automatic apply_vec(input vec_t e, input int k);
        if (e.pre_rst) do_reset();
        req_valid = e.v; req_gray = e.g; out_ready = e.rdy;
        #1;
        chk($sformatf("vec%0d req_ready", k), req_ready, e.exp_rdy);
        cycle(e.v, e.g, e.rdy);
        chk($sformatf("vec%0d out_valid", k), out_valid, e.exp_vld);
        chk($sformatf("vec%0d out_id", k), out_id, e.exp_id);
        chk($sformatf("vec%0d out_bin", k), out_bin, e.exp_bin);
    endtask

    initial begin
        logic [N*W-1:0] gv;

        // Single requester, two words back to back.
        tbl.push_back(mk(0, 4'b0001, {9'd0, 3'b010}, 1, 4'b0001, 1, 2'd0, 3'b011));
        tbl.push_back(mk(0, 4'b0001, {9'd0, 3'b011}, 1, 4'b0001, 1, 2'd0, 3'b010));
        tbl.push_back(mk(0, 4'b0000, {12'd0},        1, 4'b0000, 0, 2'd0, 3'b010));
        // All four valid, full throughput.
        tbl.push_back(mk(1, 4'b1111, c_g2, 1, 4'b0001, 1, 2'd0, 3'b111));
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b0010, 1, 2'd1, 3'b110));
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b0100, 1, 2'd2, 3'b011));
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b1000, 1, 2'd3, 3'b010));
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b0001, 1, 2'd0, 3'b111));
        // Backpressure for five cycles, then resume in order.
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b0010, 1, 2'd1, 3'b110));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b1111, c_g2, 0, 4'b0000, 1, 2'd1, 3'b110));
        tbl.push_back(mk(0, 4'b1111, c_g2, 1, 4'b0100, 1, 2'd2, 3'b011));
        // Pointer at 3 with requesters 1 and 3: wraps through 0.
        tbl.push_back(mk(0, 4'b1010, c_g2, 1, 4'b1000, 1, 2'd3, 3'b010));
        tbl.push_back(mk(0, 4'b1010, c_g2, 1, 4'b0010, 1, 2'd1, 3'b110));
        tbl.push_back(mk(0, 4'b1010, c_g2, 1, 4'b1000, 1, 2'd3, 3'b010));

        // Reset state, with all requests high to show no grant leaks during reset.
        rst_n = 1'b0; req_valid = '1; req_gray = '0; out_ready = 1'b1;
        #12;
        chk("rst req_ready", req_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_bin", out_bin, 0);
        chk("rst out_id", out_id, 0);
        chk("rst conv_count", conv_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1; req_valid = '0;
        model_reset();
        @(posedge clk); #1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply_vec(tbl[k], k);
            if (k == 2) chk("t1 conv_count", conv_count, 2);
        end

        // Asynchronous reset while a result is held.
        chk("t5 pre out_valid", out_valid, 1);
        req_valid = 4'b1010; req_gray = c_g2; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async out_valid", out_valid, 0);
        chk("t5 async out_bin", out_bin, 0);
        chk("t5 async out_id", out_id, 0);
        chk("t5 async conv_count", conv_count, 0);
        chk("t5 async req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("t5 held out_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        model_reset();
        cycle(4'b1010, c_g2, 1'b1);
        chk("t5 first grant id", out_id, 1);

        // Every Gray code on every requester.
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < 8; g++) begin
                gv = 12'($urandom);
                gv[i*W +: W] = 3'(g);
                cycle(4'b0001 << i, gv, 1'b1);
                chk($sformatf("exh r%0d g%0d bin", i, g), out_bin, bin_tbl[g]);
                chk($sformatf("exh r%0d g%0d id", i, g), out_id, i);
            end
        end

        // Counter saturation.
        while (m_count != 16'hFFFE) cycle(4'b0001, '0, 1'b1);
        chk("sat pre", conv_count, 16'hFFFE);
        repeat (3) cycle(4'b0001, '0, 1'b1);
        chk("sat conv_count", conv_count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
